// File: rtl/mem_rq_seq.sv
// mem_rq_seq: SBUS memory request sequencer for the MBOX.
// Accepts a memory start, issues the SBUS start/request, waits for ACKN,
// steps through returned read words and generates CORE_BUSY, ACKN_PULSE and
// DATA_VAL_PULSE/WD_SEL strobes.
// Optional feature: define MEM_RQ_SEQ_NXM_TIMER_EN to build the
// non-existent-memory timeout (timer, NXM state, NXM_FLG). Without it the
// sequencer waits indefinitely in WAIT_ACKN and DATA and NXM_FLG is 0.
module mem_rq_seq #(
   parameter int NXM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_start,
   input  logic       mem_rd_rq,
   input  logic       mem_wr_rq,
   input  logic [3:0] mem_rq,
   input  logic [1:0] mem_wd_adr,
   input  logic       mem_wr_go,
   input  logic       sbus_ackn,
   input  logic       sbus_data_valid,
   output logic       sbus_start,
   output logic       sbus_rd_rq,
   output logic       sbus_wr_rq,
   output logic [3:0] sbus_rq,
   output logic [1:0] sbus_adr_wd,
   output logic       core_busy,
   output logic       ackn_pulse,
   output logic       data_val_pulse,
   output logic [1:0] wd_sel,
   output logic       rd_pse_wr_ref,
   output logic       nxm_flg
);

   // The timeout counter is 8 bits wide, so only 1..255 is meaningful.
   if (NXM_TIMEOUT < 1 || NXM_TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_rq_seq: NXM_TIMEOUT must be in 1..255");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT_ACKN, S_DATA, S_PAUSE, S_NXM, S_DONE
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [3:0] rq_latch;     // request mask as accepted
   logic [1:0] adr_latch;    // starting word as accepted
   logic [3:0] remain;       // words still to be delivered
   logic [1:0] ptr;          // word pointer for the wrap-around search
   logic       is_wr;        // current half is a write
   logic       rpw;          // read-pause-write in progress
   logic       accept;
   logic [1:0] pick_wd;
   logic [3:0] remain_after;
   logic       last_word;

`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(NXM_TIMEOUT - 1);
   logic [7:0] timer;
   logic       timeout;
   logic       nxm_flg_r;
`endif

   assign accept = (state == S_IDLE) && mem_start && (mem_rd_rq || mem_wr_rq)
                   && (mem_rq != 4'b0000);

   // Lowest-numbered remaining word at or after the pointer, modulo 4.
   always_comb begin
      pick_wd = ptr;
      for (int i = 3; i >= 0; i--) begin
         if (remain[ptr + 2'(i)]) pick_wd = ptr + 2'(i);
      end
   end

   assign remain_after = remain & ~(4'b0001 << pick_wd);
   assign last_word    = (remain_after == 4'b0000);

`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
   // The count reaching NXM_TIMEOUT on this edge aborts the cycle.
   assign timeout = (timer == TIMEOUT_LAST);
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic; ACKN / DATA_VALID take priority over the timeout.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:      if (accept) state_next = S_START;
         S_START:     state_next = S_WAIT_ACKN;
         S_WAIT_ACKN: begin
            if (sbus_ackn) state_next = is_wr ? S_DONE : S_DATA;
`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
            else if (timeout) state_next = S_NXM;
`endif
         end
         S_DATA: begin
            if (sbus_data_valid) begin
               if (last_word) state_next = rpw ? S_PAUSE : S_DONE;
            end
`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
            else if (timeout) state_next = S_NXM;
`endif
         end
         S_PAUSE:     if (mem_wr_go) state_next = S_START;
`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
         S_NXM:       if (is_wr || last_word) state_next = S_DONE;
`endif
         S_DONE:      state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // Combinational outputs decoded from state and the latched request type.
   always_comb begin
      core_busy  = (state != S_IDLE);
      sbus_rd_rq = 1'b0;
      sbus_wr_rq = 1'b0;
      if (state != S_IDLE && state != S_PAUSE) begin
         sbus_rd_rq = !is_wr;
         sbus_wr_rq = is_wr;
      end
   end

   assign sbus_rq       = rq_latch;
   assign sbus_adr_wd   = adr_latch;
   assign rd_pse_wr_ref = rpw;

   // Request latches, word stepping and the registered strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rq_latch       <= 4'b0000;
         adr_latch      <= 2'd0;
         remain         <= 4'b0000;
         ptr            <= 2'd0;
         is_wr          <= 1'b0;
         rpw            <= 1'b0;
         sbus_start     <= 1'b0;
         ackn_pulse     <= 1'b0;
         data_val_pulse <= 1'b0;
         wd_sel         <= 2'd0;
      end else begin
         sbus_start     <= (state == S_START);
         ackn_pulse     <= (state == S_WAIT_ACKN) && sbus_ackn;
         data_val_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rq_latch  <= mem_rq;
                  adr_latch <= mem_wd_adr;
                  remain    <= mem_rq;
                  ptr       <= mem_wd_adr;
                  is_wr     <= mem_wr_rq && !mem_rd_rq;
                  rpw       <= mem_rd_rq && mem_wr_rq;
               end
            end
            S_WAIT_ACKN: begin
               if (sbus_ackn && !is_wr) begin
                  remain <= rq_latch;
                  ptr    <= adr_latch;
               end
            end
            S_DATA: begin
               if (sbus_data_valid) begin
                  data_val_pulse <= 1'b1;
                  wd_sel         <= pick_wd;
                  remain         <= remain_after;
                  ptr            <= pick_wd + 2'd1;
               end
            end
            S_PAUSE: begin
               if (mem_wr_go) is_wr <= 1'b1;
            end
`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
            // Substitute the words memory never returned, in DATA order.
            S_NXM: begin
               if (!is_wr) begin
                  data_val_pulse <= 1'b1;
                  wd_sel         <= pick_wd;
                  remain         <= remain_after;
                  ptr            <= pick_wd + 2'd1;
               end
            end
`endif
            S_DONE: rpw <= 1'b0;
            default: ;
         endcase
`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
         // A timeout abandons any pending write half.
         if (state_next == S_NXM) rpw <= 1'b0;
`endif
      end
   end

`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
   // Timer runs while waiting on memory and clears on every ACKN / data word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timer <= 8'd0;
      else if ((state == S_WAIT_ACKN && !sbus_ackn) ||
               (state == S_DATA && !sbus_data_valid))
         timer <= timer + 8'd1;
      else
         timer <= 8'd0;
   end

   // NXM flag holds from the timeout until DONE is left.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    nxm_flg_r <= 1'b0;
      else if (state == S_DONE)     nxm_flg_r <= 1'b0;
      else if (state_next == S_NXM) nxm_flg_r <= 1'b1;
   end

   assign nxm_flg = nxm_flg_r;
`else
   assign nxm_flg = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rq_seq.sv
// Directed testbench for mem_rq_seq. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, so every check sees the
// state produced by the edge just passed.
module tb_mem_rq_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       mem_start;
   logic       mem_rd_rq;
   logic       mem_wr_rq;
   logic [3:0] mem_rq;
   logic [1:0] mem_wd_adr;
   logic       mem_wr_go;
   logic       sbus_ackn;
   logic       sbus_data_valid;
   logic       sbus_start;
   logic       sbus_rd_rq;
   logic       sbus_wr_rq;
   logic [3:0] sbus_rq;
   logic [1:0] sbus_adr_wd;
   logic       core_busy;
   logic       ackn_pulse;
   logic       data_val_pulse;
   logic [1:0] wd_sel;
   logic       rd_pse_wr_ref;
   logic       nxm_flg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_rq_seq #(.NXM_TIMEOUT(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_start       (mem_start),
      .mem_rd_rq       (mem_rd_rq),
      .mem_wr_rq       (mem_wr_rq),
      .mem_rq          (mem_rq),
      .mem_wd_adr      (mem_wd_adr),
      .mem_wr_go       (mem_wr_go),
      .sbus_ackn       (sbus_ackn),
      .sbus_data_valid (sbus_data_valid),
      .sbus_start      (sbus_start),
      .sbus_rd_rq      (sbus_rd_rq),
      .sbus_wr_rq      (sbus_wr_rq),
      .sbus_rq         (sbus_rq),
      .sbus_adr_wd     (sbus_adr_wd),
      .core_busy       (core_busy),
      .ackn_pulse      (ackn_pulse),
      .data_val_pulse  (data_val_pulse),
      .wd_sel          (wd_sel),
      .rd_pse_wr_ref   (rd_pse_wr_ref),
      .nxm_flg         (nxm_flg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a one-cycle MEM_START; returns just after the accepting edge.
   task automatic start_rq(input logic rd, input logic wr,
                           input logic [3:0] rq, input logic [1:0] adr);
      mem_start = 1'b1; mem_rd_rq = rd; mem_wr_rq = wr;
      mem_rq = rq; mem_wd_adr = adr;
      tick();
      mem_start = 1'b0; mem_rd_rq = 1'b0; mem_wr_rq = 1'b0;
      mem_rq = 4'b0000; mem_wd_adr = 2'd0;
   endtask

   task automatic test_reset();
      logic [17:0] outs;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      outs = {sbus_start, sbus_rd_rq, sbus_wr_rq, sbus_rq, sbus_adr_wd, core_busy,
              ackn_pulse, data_val_pulse, wd_sel, rd_pse_wr_ref, nxm_flg, 1'b0};
      n_tests++;
      if (outs !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if (core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b expected 0", core_busy);
      end
      $display("[TB] reset: outputs=%h", outs);
   endtask

   task automatic test_read_quad();
      logic [1:0] exp_sel [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
      start_rq(1'b1, 1'b0, 4'b1111, 2'd2);
      n_tests++;
      if (core_busy !== 1'b1 || sbus_start !== 1'b0) begin
         n_fail++;
         $display("FAIL rdq_accept: busy=%b start=%b expected 1,0", core_busy, sbus_start);
      end
      tick();
      n_tests++;
      if ({sbus_start, sbus_rd_rq, sbus_wr_rq, sbus_rq, sbus_adr_wd} !== {3'b110, 4'b1111, 2'd2}) begin
         n_fail++;
         $display("FAIL rdq_start: start=%b rd=%b wr=%b rq=%b adr=%0d expected 1,1,0,1111,2",
                  sbus_start, sbus_rd_rq, sbus_wr_rq, sbus_rq, sbus_adr_wd);
      end
      tick(); tick();
      n_tests++;
      if (sbus_start !== 1'b0) begin
         n_fail++;
         $display("FAIL rdq_start_width: got %b expected 0", sbus_start);
      end
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      n_tests++;
      if (ackn_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL rdq_ackn_pulse: got %b expected 1", ackn_pulse);
      end
      tick();
      n_tests++;
      if (ackn_pulse !== 1'b0 || data_val_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL rdq_ackn_once: ackn=%b dv=%b expected 0,0", ackn_pulse, data_val_pulse);
      end
      sbus_data_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 3) sbus_data_valid = 1'b0;
         n_tests++;
         if (data_val_pulse !== 1'b1 || wd_sel !== exp_sel[k] || core_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rdq_word%0d: dv=%b wd_sel=%0d busy=%b expected 1,%0d,1",
                     k, data_val_pulse, wd_sel, core_busy, exp_sel[k]);
         end
      end
      tick();
      n_tests++;
      if (core_busy !== 1'b0 || data_val_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL rdq_done: busy=%b dv=%b expected 0,0", core_busy, data_val_pulse);
      end
      $display("[TB] read quad: rq=1111 adr=2 complete");
   endtask

   // Write; stray DATA_VALID held high the whole time must produce no pulses.
   task automatic test_write();
      int busy_cnt = 0, ackn_cnt = 0, dv_cnt = 0, start_cnt = 0;
      logic wr_at_start = 1'b0;
      sbus_data_valid = 1'b1;
      start_rq(1'b0, 1'b1, 4'b0001, 2'd0);
      busy_cnt += int'(core_busy);
      for (int c = 1; c < 10; c++) begin
         sbus_ackn = (c == 5);
         tick();
         busy_cnt  += int'(core_busy);
         ackn_cnt  += int'(ackn_pulse);
         dv_cnt    += int'(data_val_pulse);
         start_cnt += int'(sbus_start);
         if (sbus_start) wr_at_start = sbus_wr_rq && !sbus_rd_rq;
      end
      sbus_ackn = 1'b0; sbus_data_valid = 1'b0;
      n_tests++;
      if (busy_cnt !== 6) begin
         n_fail++;
         $display("FAIL wr_busy_cycles: got %0d expected 6", busy_cnt);
      end
      n_tests++;
      if (ackn_cnt !== 1 || dv_cnt !== 0) begin
         n_fail++;
         $display("FAIL wr_pulses: ackn=%0d dv=%0d expected 1,0", ackn_cnt, dv_cnt);
      end
      n_tests++;
      if (start_cnt !== 1 || wr_at_start !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_start: starts=%0d wr_type=%b expected 1,1", start_cnt, wr_at_start);
      end
      $display("[TB] write: busy=%0d ackn=%0d dv=%0d", busy_cnt, ackn_cnt, dv_cnt);
   endtask

   task automatic test_read_pause_write();
      int bad = 0;
      start_rq(1'b1, 1'b1, 4'b0010, 2'd1);
      tick();
      n_tests++;
      if (sbus_start !== 1'b1 || sbus_rd_rq !== 1'b1 || sbus_wr_rq !== 1'b0 || rd_pse_wr_ref !== 1'b1) begin
         n_fail++;
         $display("FAIL rpw_read_start: start=%b rd=%b wr=%b rpw=%b expected 1,1,0,1",
                  sbus_start, sbus_rd_rq, sbus_wr_rq, rd_pse_wr_ref);
      end
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      sbus_data_valid = 1'b1; tick(); sbus_data_valid = 1'b0;
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL rpw_read_word: dv=%b wd_sel=%0d expected 1,1", data_val_pulse, wd_sel);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         if (core_busy !== 1'b1 || rd_pse_wr_ref !== 1'b1 || sbus_start !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL rpw_pause_hold: bad cycles=%0d expected 0", bad);
      end
      mem_wr_go = 1'b1; tick(); mem_wr_go = 1'b0;
      tick();
      n_tests++;
      if (sbus_start !== 1'b1 || sbus_wr_rq !== 1'b1 || sbus_rd_rq !== 1'b0) begin
         n_fail++;
         $display("FAIL rpw_write_start: start=%b wr=%b rd=%b expected 1,1,0",
                  sbus_start, sbus_wr_rq, sbus_rd_rq);
      end
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      n_tests++;
      if (core_busy !== 1'b1 || rd_pse_wr_ref !== 1'b1 || ackn_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL rpw_done: busy=%b rpw=%b ackn=%b expected 1,1,1",
                  core_busy, rd_pse_wr_ref, ackn_pulse);
      end
      tick();
      n_tests++;
      if (core_busy !== 1'b0 || rd_pse_wr_ref !== 1'b0) begin
         n_fail++;
         $display("FAIL rpw_idle: busy=%b rpw=%b expected 0,0", core_busy, rd_pse_wr_ref);
      end
      $display("[TB] read-pause-write: word 1 then write half");
   endtask

   task automatic test_rejected_start();
      start_rq(1'b1, 1'b0, 4'b0000, 2'd0);
      n_tests++;
      if (core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_zero_mask: busy=%b expected 0", core_busy);
      end
      start_rq(1'b0, 1'b0, 4'b1111, 2'd0);
      n_tests++;
      if (core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_no_type: busy=%b expected 0", core_busy);
      end
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      sbus_data_valid = 1'b1; tick(); sbus_data_valid = 1'b0;
      n_tests++;
      if (ackn_pulse !== 1'b0 || data_val_pulse !== 1'b0 || core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_strays: ackn=%b dv=%b busy=%b expected 0,0,0",
                  ackn_pulse, data_val_pulse, core_busy);
      end
      $display("[TB] rejected starts and idle strays");
   endtask

   task automatic test_busy_start_ignored();
      start_rq(1'b1, 1'b0, 4'b0001, 2'd0);
      mem_start = 1'b1; mem_wr_rq = 1'b1; mem_rq = 4'b1100; mem_wd_adr = 2'd3;
      tick(); tick();
      mem_start = 1'b0; mem_wr_rq = 1'b0; mem_rq = 4'b0000; mem_wd_adr = 2'd0;
      n_tests++;
      if (sbus_rq !== 4'b0001 || sbus_adr_wd !== 2'd0 || sbus_rd_rq !== 1'b1 || sbus_wr_rq !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_latch: rq=%b adr=%0d rd=%b wr=%b expected 0001,0,1,0",
                  sbus_rq, sbus_adr_wd, sbus_rd_rq, sbus_wr_rq);
      end
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      sbus_data_valid = 1'b1; tick(); sbus_data_valid = 1'b0;
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL busy_start_word: dv=%b wd_sel=%0d expected 1,0", data_val_pulse, wd_sel);
      end
      tick(); tick();
      n_tests++;
      if (core_busy !== 1'b0 || sbus_start !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_after: busy=%b start=%b expected 0,0", core_busy, sbus_start);
      end
      $display("[TB] start while busy ignored");
   endtask

`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
   task automatic test_nxm();
      start_rq(1'b1, 1'b0, 4'b1010, 2'd0);
      repeat (8) tick();
      n_tests++;
      if (nxm_flg !== 1'b0 || core_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nxm_early: nxm=%b busy=%b expected 0,1", nxm_flg, core_busy);
      end
      tick();
      n_tests++;
      if (nxm_flg !== 1'b1 || data_val_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL nxm_flag: nxm=%b dv=%b expected 1,0", nxm_flg, data_val_pulse);
      end
      tick();
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL nxm_word1: dv=%b wd_sel=%0d expected 1,1", data_val_pulse, wd_sel);
      end
      tick();
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd3 || nxm_flg !== 1'b1 || core_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nxm_word3: dv=%b wd_sel=%0d nxm=%b busy=%b expected 1,3,1,1",
                  data_val_pulse, wd_sel, nxm_flg, core_busy);
      end
      tick();
      n_tests++;
      if (core_busy !== 1'b0 || nxm_flg !== 1'b0 || data_val_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL nxm_idle: busy=%b nxm=%b dv=%b expected 0,0,0",
                  core_busy, nxm_flg, data_val_pulse);
      end
      $display("[TB] nxm timeout read rq=1010");
   endtask

   task automatic test_ackn_at_timeout();
      start_rq(1'b1, 1'b0, 4'b0001, 2'd0);
      repeat (8) tick();
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      n_tests++;
      if (ackn_pulse !== 1'b1 || nxm_flg !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_ackn: ackn=%b nxm=%b expected 1,0", ackn_pulse, nxm_flg);
      end
      sbus_data_valid = 1'b1; tick(); sbus_data_valid = 1'b0;
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd0 || nxm_flg !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_word: dv=%b wd_sel=%0d nxm=%b expected 1,0,0",
                  data_val_pulse, wd_sel, nxm_flg);
      end
      tick();
      n_tests++;
      if (core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_idle: busy=%b expected 0", core_busy);
      end
      $display("[TB] ackn on timeout edge completes normally");
   endtask
`else
   task automatic test_no_timeout();
      start_rq(1'b1, 1'b0, 4'b1010, 2'd0);
      repeat (300) tick();
      n_tests++;
      if (core_busy !== 1'b1 || nxm_flg !== 1'b0 || data_val_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL hang_busy: busy=%b nxm=%b dv=%b expected 1,0,0",
                  core_busy, nxm_flg, data_val_pulse);
      end
      reset = 1'b1; #1;
      n_tests++;
      if (core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hang_reset: busy=%b expected 0", core_busy);
      end
      tick(); reset = 1'b0; tick();
      $display("[TB] no timeout: still busy after 300 cycles");
   endtask
`endif

   task automatic test_reset_mid_data();
      logic [17:0] outs;
      start_rq(1'b1, 1'b0, 4'b1111, 2'd0);
      tick();
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      sbus_data_valid = 1'b1; tick(); tick();
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL rstmid_word1: dv=%b wd_sel=%0d expected 1,1", data_val_pulse, wd_sel);
      end
      #3; reset = 1'b1; #1;
      sbus_data_valid = 1'b0;
      outs = {sbus_start, sbus_rd_rq, sbus_wr_rq, sbus_rq, sbus_adr_wd, core_busy,
              ackn_pulse, data_val_pulse, wd_sel, rd_pse_wr_ref, nxm_flg, 1'b0};
      n_tests++;
      if (outs !== 18'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got %h expected 0", outs);
      end
      tick(); reset = 1'b0; tick();
      start_rq(1'b1, 1'b0, 4'b0100, 2'd3);
      tick();
      sbus_ackn = 1'b1; tick(); sbus_ackn = 1'b0;
      sbus_data_valid = 1'b1; tick(); sbus_data_valid = 1'b0;
      n_tests++;
      if (data_val_pulse !== 1'b1 || wd_sel !== 2'd2) begin
         n_fail++;
         $display("FAIL rstmid_fresh: dv=%b wd_sel=%0d expected 1,2", data_val_pulse, wd_sel);
      end
      tick();
      n_tests++;
      if (core_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: busy=%b expected 0", core_busy);
      end
      $display("[TB] reset mid-data then fresh read");
   endtask

   initial begin
      reset = 1'b1; mem_start = 1'b0; mem_rd_rq = 1'b0; mem_wr_rq = 1'b0;
      mem_rq = 4'b0000; mem_wd_adr = 2'd0; mem_wr_go = 1'b0;
      sbus_ackn = 1'b0; sbus_data_valid = 1'b0;
      test_reset();
      test_read_quad();
      test_write();
      test_read_pause_write();
      test_rejected_start();
      test_busy_start_ignored();
`ifdef MEM_RQ_SEQ_NXM_TIMER_EN
      test_nxm();
      test_ackn_at_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_data();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
